// File: rtl/tree_reduction_controller.sv
// Streaming vector reducer: sums VEC_LEN signed elements that arrive TREE_INPUTS per beat
// through one shared adder tree, then holds the result until the consumer takes it.

module binary_tree_adder #(
    parameter int INPUTS_AMOUNT  = 8,
    parameter int OUTPUTS_AMOUNT = 1,
    parameter int P              = 16
) (
    input  logic signed [P-1:0] in_data  [INPUTS_AMOUNT],
    output logic signed [P-1:0] out_data [OUTPUTS_AMOUNT]
);

    localparam int OUT_LEVEL = $clog2(INPUTS_AMOUNT / OUTPUTS_AMOUNT);

    generate
        if ((INPUTS_AMOUNT < 2) || ((INPUTS_AMOUNT & (INPUTS_AMOUNT - 1)) != 0)) begin : g_bad_inputs
            $fatal(1, "binary_tree_adder: INPUTS_AMOUNT must be a power of 2, at least 2");
        end
        if ((OUTPUTS_AMOUNT < 1) || (OUTPUTS_AMOUNT > INPUTS_AMOUNT) ||
            ((OUTPUTS_AMOUNT & (OUTPUTS_AMOUNT - 1)) != 0)) begin : g_bad_outputs
            $fatal(1, "binary_tree_adder: OUTPUTS_AMOUNT must be a power of 2 no larger than INPUTS_AMOUNT");
        end

        // Each level halves the lane count; sums wrap modulo 2**P like the accumulator downstream.
        for (genvar l = 0; l <= OUT_LEVEL; l++) begin : g_lvl
            logic signed [P-1:0] sum [INPUTS_AMOUNT >> l];
            if (l == 0) begin : g_leaf
                for (genvar i = 0; i < INPUTS_AMOUNT; i++) begin : g_lane
                    assign sum[i] = in_data[i];
                end
            end else begin : g_add
                for (genvar i = 0; i < (INPUTS_AMOUNT >> l); i++) begin : g_pair
                    assign sum[i] = g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
                end
            end
        end

        for (genvar o = 0; o < OUTPUTS_AMOUNT; o++) begin : g_out
            assign out_data[o] = g_lvl[OUT_LEVEL].sum[o];
        end
    endgenerate

endmodule

module tree_reduction_controller #(
    parameter int P           = 16,
    parameter int TREE_INPUTS = 8,
    parameter int VEC_LEN     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [P-1:0] in_data [TREE_INPUTS],
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [P-1:0] out_sum,
    output logic                busy
);

    localparam int BEATS = VEC_LEN / TREE_INPUTS;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    beat_cnt;
    logic [CNT_W-1:0]    beat_cnt_next;
    logic signed [P-1:0] acc;
    logic signed [P-1:0] acc_next;
    logic signed [P-1:0] out_sum_next;
    logic signed [P-1:0] beat_sum;
    logic signed [P-1:0] tree_sum;
    logic signed [P-1:0] tree_out [1];
    logic                out_valid_next;
    logic                ready_en;
    logic                accept;

    generate
        if ((TREE_INPUTS < 2) || ((TREE_INPUTS & (TREE_INPUTS - 1)) != 0)) begin : g_bad_tree
            $fatal(1, "tree_reduction_controller: TREE_INPUTS must be a power of 2, at least 2");
        end
        if ((VEC_LEN < TREE_INPUTS) || ((VEC_LEN % TREE_INPUTS) != 0)) begin : g_bad_len
            $fatal(1, "tree_reduction_controller: VEC_LEN must be a positive multiple of TREE_INPUTS");
        end
    endgenerate

    binary_tree_adder #(
        .INPUTS_AMOUNT (TREE_INPUTS),
        .OUTPUTS_AMOUNT(1),
        .P             (P)
    ) u_tree (
        .in_data (in_data),
        .out_data(tree_out)
    );

    assign tree_sum = tree_out[0];
    assign in_ready = ready_en && (state != HOLD);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // ready_en keeps in_ready low through reset and releases it on the first clock afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            beat_cnt  <= beat_cnt_next;
            acc       <= acc_next;
            out_sum   <= out_sum_next;
            out_valid <= out_valid_next;
        end
    end

    // The first beat of a vector starts from zero, so a stale acc never leaks into a new vector.
    always_comb begin
        state_next     = state;
        beat_cnt_next  = beat_cnt;
        acc_next       = acc;
        out_sum_next   = out_sum;
        out_valid_next = out_valid;
        beat_sum       = ((beat_cnt == '0) ? '0 : acc) + tree_sum;

        case (state)
            IDLE, ACCUM: begin
                if (flush) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                    acc_next      = '0;
                end else if (accept) begin
                    acc_next = beat_sum;
                    if (beat_cnt == LAST_BEAT) begin
                        out_sum_next   = beat_sum;
                        out_valid_next = 1'b1;
                        beat_cnt_next  = '0;
                        state_next     = HOLD;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                        state_next    = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tree_reduction_controller.sv
// Bench for tree_reduction_controller (P=8, 4 lanes, 8-element vectors): directed scenarios
// with hand-computed sums, then random traffic against a queue-based vector-sum model.

module tb_tree_reduction_controller;

    localparam int P  = 8;
    localparam int TI = 4;
    localparam int VL = 8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [P-1:0] in_data [TI];
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic signed [P-1:0] out_sum;
    logic                busy;

    int errors = 0;
    int checks = 0;

    int                  m_elems [$];
    logic                m_pending;
    logic signed [P-1:0] m_sum;
    logic                m_ready_seen;

    tree_reduction_controller #(
        .P          (P),
        .TREE_INPUTS(TI),
        .VEC_LEN    (VL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic step(input logic v, input logic [31:0] beat, input logic fl, input logic ordy);
        in_valid  = v;
        flush     = fl;
        out_ready = ordy;
        for (int i = 0; i < TI; i++) in_data[i] = beat[8*i +: 8];
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_elems.delete();
        m_pending    = 1'b0;
        m_sum        = '0;
        m_ready_seen = 1'b0;
    endtask

    // Vector-level behaviour: collect elements, emit their wrapped sum once VL have arrived.
    task automatic model_edge();
        logic rdy;
        int   s;
        rdy = m_ready_seen && !m_pending;
        if (m_pending) begin
            if (out_ready) m_pending = 1'b0;
        end else if (flush) begin
            m_elems.delete();
        end else if (in_valid && rdy) begin
            for (int i = 0; i < TI; i++) m_elems.push_back(int'(in_data[i]));
            if (m_elems.size() == VL) begin
                s = 0;
                foreach (m_elems[k]) s += m_elems[k];
                m_sum     = s[7:0];
                m_pending = 1'b1;
                m_elems.delete();
            end
        end
        m_ready_seen = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_sum !== 8'sd0) begin errors++; $display("[TB] FAIL reset_out_sum: got %0d want 0", out_sum); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_ready_early: got %b want 0", in_ready); end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_sum();
        step(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b0);
        checks++; if ({out_valid, busy} !== 2'b01) begin errors++; $display("[TB] FAIL basic_first_beat: got valid/busy %b want 01", {out_valid, busy}); end
        step(1'b1, pack4(5, 6, 7, 8), 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_sum !== 8'sd36) begin errors++; $display("[TB] FAIL basic_sum: got %0d want 36", out_sum); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_hold_ready: got %b want 0", in_ready); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin errors++; $display("[TB] FAIL basic_consume: got valid/busy/ready %b want 001", {out_valid, busy, in_ready}); end
    endtask

    task automatic test_wrap();
        step(1'b1, pack4(127, 127, 127, 127), 1'b0, 1'b0);
        step(1'b1, pack4(127, 127, 127, 127), 1'b0, 1'b0);
        checks++; if ({out_valid, out_sum} !== {1'b1, 8'shF8}) begin errors++; $display("[TB] FAIL wrap_sum: got valid %b sum %0d want valid 1 sum -8", out_valid, out_sum); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_consume: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        step(1'b1, pack4(10, 20, 30, 40), 1'b0, 1'b0);
        step(1'b1, pack4(-5, -5, -5, -5), 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, pack4(1, 1, 1, 1), 1'b0, 1'b0);
            checks++; if ({out_valid, in_ready, busy} !== 3'b101) begin errors++; $display("[TB] FAIL bp_hold_flags cycle %0d: got valid/ready/busy %b want 101", c, {out_valid, in_ready, busy}); end
            checks++; if (out_sum !== 8'sd80) begin errors++; $display("[TB] FAIL bp_hold_sum cycle %0d: got %0d want 80", c, out_sum); end
        end
        step(1'b1, pack4(1, 1, 1, 1), 1'b0, 1'b1);
        checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin errors++; $display("[TB] FAIL bp_release: got valid/busy/ready %b want 001", {out_valid, busy, in_ready}); end
        step(1'b1, pack4(2, 2, 2, 2), 1'b0, 1'b1);
        step(1'b1, pack4(3, 3, 3, 3), 1'b0, 1'b1);
        checks++; if ({out_valid, out_sum} !== {1'b1, 8'sd20}) begin errors++; $display("[TB] FAIL bp_no_residue: got valid %b sum %0d want valid 1 sum 20", out_valid, out_sum); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        step(1'b1, pack4(9, 9, 9, 9), 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got busy %b want 0", busy); end
        step(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b0);
        step(1'b1, pack4(5, 6, 7, 8), 1'b0, 1'b0);
        checks++; if ({out_valid, out_sum} !== {1'b1, 8'sd36}) begin errors++; $display("[TB] FAIL flush_clean_sum: got valid %b sum %0d want valid 1 sum 36", out_valid, out_sum); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, pack4(1, 1, 1, 1), 1'b0, 1'b1);
        step(1'b1, pack4(2, 2, 2, 2), 1'b1, 1'b1);
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL flush_beats_last: got valid/busy %b want 00", {out_valid, busy}); end
        step(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b0);
        step(1'b1, pack4(4, 3, 2, 1), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if ({out_valid, out_sum} !== {1'b1, 8'sd20}) begin errors++; $display("[TB] FAIL flush_in_hold: got valid %b sum %0d want valid 1 sum 20", out_valid, out_sum); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        step(1'b1, pack4(1, 2, 3, 4), 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_busy: got %b want 1", busy); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, busy, in_ready} !== 3'b000) begin errors++; $display("[TB] FAIL areset_flags: got valid/busy/ready %b want 000", {out_valid, busy, in_ready}); end
        checks++; if (out_sum !== 8'sd0) begin errors++; $display("[TB] FAIL areset_sum: got %0d want 0", out_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, pack4(-1, -2, -3, -4), 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_no_residue_early: got valid %b want 0", out_valid); end
        step(1'b1, pack4(0, 0, 0, 10), 1'b0, 1'b0);
        checks++; if ({out_valid, out_sum} !== {1'b1, 8'sd0}) begin errors++; $display("[TB] FAIL areset_next_vector: got valid %b sum %0d want valid 1 sum 0", out_valid, out_sum); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int pick;
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < TI; i++) begin
                pick = $urandom_range(0, 5);
                if (pick == 0)      in_data[i] = 8'sd127;
                else if (pick == 1) in_data[i] = -8'sd128;
                else                in_data[i] = 8'($urandom);
            end
            @(posedge clk);
            model_edge();
            #1;
            checks++; if (out_valid !== m_pending) begin errors++; $display("[TB] FAIL rand_valid cycle %0d: got %b want %b", c, out_valid, m_pending); end
            checks++; if (out_sum !== m_sum) begin errors++; $display("[TB] FAIL rand_sum cycle %0d: got %0d want %0d", c, out_sum, m_sum); end
            checks++; if (in_ready !== (m_ready_seen && !m_pending)) begin errors++; $display("[TB] FAIL rand_ready cycle %0d: got %b want %b", c, in_ready, m_ready_seen && !m_pending); end
            checks++; if (busy !== (m_pending || (m_elems.size() > 0))) begin errors++; $display("[TB] FAIL rand_busy cycle %0d: got %b want %b", c, busy, m_pending || (m_elems.size() > 0)); end
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < TI; i++) in_data[i] = '0;
        test_reset();
        test_basic_sum();
        test_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tree_reduction_controller.md
TREE_REDUCTION_CONTROLLER -- requirements
Module: tree_reduction_controller

Interface
REQ-001 SHALL have parameter P, default 16: element, partial-sum and result width in bits, signed two's complement.
REQ-002 SHALL have parameter TREE_INPUTS, default 8: lanes per beat and input count of the shared binary_tree_adder; power of 2, at least 2.
REQ-003 SHALL have parameter VEC_LEN, default 64: elements per vector; integer multiple of TREE_INPUTS. BEATS = VEC_LEN/TREE_INPUTS.
REQ-004 SHALL abort elaboration with $fatal if TREE_INPUTS is not a power of 2 or VEC_LEN is not a multiple of TREE_INPUTS.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data carries a valid beat.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, signed [P-1:0] x TREE_INPUTS (unpacked array): one beat of TREE_INPUTS elements.
REQ-010 SHALL have port flush, input, 1 bit: synchronous discard of the partial vector.
REQ-011 SHALL have port out_valid, output, 1 bit: out_sum holds a completed vector sum.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts out_sum.
REQ-013 SHALL have port out_sum, output, signed [P-1:0]: sum of all VEC_LEN elements of one vector.
REQ-014 SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-015 SHALL instantiate exactly one binary_tree_adder (INPUTS_AMOUNT=TREE_INPUTS, OUTPUTS_AMOUNT=1, P=P), driven directly by in_data; tree_sum is its single output.
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-017 SHALL define a beat as accepted on a rising edge where in_valid && in_ready.
REQ-018 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-019 SHALL keep a beat counter of width clog2(BEATS)+1, counting 0..BEATS-1.
REQ-020 SHALL, on an accepted beat, compute acc = (beat_cnt==0 ? 0 : acc) + tree_sum, truncated to P bits with modular wrap and no saturation.
REQ-021 SHALL handle transitions: IDLE -> ACCUM on the first accepted beat when BEATS>1; ACCUM stays in ACCUM while beat_cnt<BEATS-1.
REQ-022 SHALL, on the accepted beat with beat_cnt==BEATS-1, register the final sum into out_sum, set out_valid, reset beat_cnt to 0, and move to HOLD.
REQ-023 SHALL assert out_valid on the cycle after the last beat is accepted (latency 1 clock).
REQ-024 SHALL, when BEATS==1, go from IDLE directly to HOLD on each accepted beat.
REQ-025 SHALL, in HOLD, keep out_sum and out_valid stable until out_valid && out_ready; on that edge it clears out_valid and moves to IDLE.
REQ-026 SHALL, when flush is high on an edge in IDLE or ACCUM, clear beat_cnt and acc, go to IDLE, and ignore any beat presented that cycle (flush wins over the last beat).
REQ-027 SHALL ignore flush in HOLD, so a pending result is never lost.
REQ-028 SHALL ignore in_data while in_valid is 0, and never produce an X on out_sum after reset.

Reset
REQ-029 SHALL, on rst_n low, immediately force state=IDLE, beat_cnt=0, acc=0, out_sum=0 and out_valid=0, independent of clk.
REQ-030 SHALL hold in_ready=0 and busy=0 during reset, and in_ready=1 from the first edge after rst_n deasserts.
REQ-031 SHALL discard any partial vector or pending result when reset is asserted mid-operation.

Verification (P=8, TREE_INPUTS=4, VEC_LEN=8)
REQ-032 SHALL cover: beats [1,2,3,4] then [5,6,7,8] -> out_valid=1 one cycle after beat 2, out_sum=36.
REQ-033 SHALL cover: two beats, all lanes 127 -> out_sum=-8 (1016 mod 256 as signed 8-bit).
REQ-034 SHALL cover: out_ready=0 for 3 cycles after result -> out_valid=1, out_sum stable, in_ready=0 for 3 cycles; accepted on the 4th cycle, then IDLE.
REQ-035 SHALL cover: beat [9,9,9,9], then flush, then [1,2,3,4],[5,6,7,8] -> out_sum=36 with no residue; flush coincident with the second beat -> no out_valid.
REQ-036 SHALL cover: rst_n low mid-cycle after one beat -> out_valid, out_sum and busy are 0 asynchronously; the next full vector [-1,-2,-3,-4],[0,0,0,10] -> out_sum=0.
